alu_ga_stim_gen: RTL

// Hardware stimulus generator for the ALU DUT, driven by one GA chromosome:
// per-field range tables (delay, REG_A, REG_B, MEM, IMM), programmed over a

---
 rtl/alu_ga_stim_gen.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_ga_stim_gen.sv
// GA-driven ALU stimulus generator: per-field range tables seeded by a 32-bit
// Galois LFSR, emitting TRANS_COUNT transactions over a valid/ready handshake.
module alu_ga_stim_gen #(
    parameter int DATA_WIDTH    = 8,
    parameter int DELAY_WIDTH   = 8,
    parameter int NUM_RANGES    = 8,
    parameter int TRANS_CNT_DEF = 100
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CFG_WE,
    input  logic [7:0]            CFG_ADDR,
    input  logic [31:0]           CFG_WDATA,
    input  logic                  START,
    input  logic                  STOP,
    output logic                  TX_VLD,
    input  logic                  TX_DST_RDY,
    output logic [3:0]            TX_OP,
    output logic [1:0]            TX_MOVI,
    output logic [DATA_WIDTH-1:0] TX_REG_A,
    output logic [DATA_WIDTH-1:0] TX_REG_B,
    output logic [DATA_WIDTH-1:0] TX_MEM,
    output logic [DATA_WIDTH-1:0] TX_IMM,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [31:0]           SENT_CNT
);
    localparam int FW = (DATA_WIDTH > DELAY_WIDTH) ? DATA_WIDTH : DELAY_WIDTH;
    localparam int IW = $clog2(NUM_RANGES);
    localparam logic [3:0]  NR   = 4'(NUM_RANGES);
    localparam logic [31:0] POLY = 32'h8020_0003;

    typedef enum logic [2:0] {IDLE, GEN, DLY, OUT, FIN} state_t;
    state_t state, nxt;

    logic [FW-1:0]          base [5][NUM_RANGES];
    logic [FW-1:0]          mask [5][NUM_RANGES];
    logic [3:0]             rc   [5];
    logic [31:0]            trans_count, seed, lfsr;
    logic [2:0]             g;
    logic [DELAY_WIDTH-1:0] dly;
    logic                   stop_pend;
    logic [2:0]             fsel;
    logic [IW-1:0]          idx;
    logic [FW-1:0]          draw;
    logic                   start_ok;

    assign TX_VLD   = (state == OUT);
    assign BUSY     = (state != IDLE);
    assign DONE     = (state == FIN);
    assign start_ok = START && !STOP;

    // Range pick and masked random draw for the field selected by GEN cycle g
    always_comb begin
        fsel = (g < 3'd5) ? g : 3'd0;
        idx  = IW'({1'b0, lfsr[2:0]} % rc[fsel]);
        draw = base[fsel][idx] | (lfsr[8 +: FW] & mask[fsel][idx]);
    end

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (start_ok) nxt = (trans_count == 32'd0) ? FIN : GEN;
            GEN: begin
                if (STOP)            nxt = IDLE;
                else if (g == 3'd5)  nxt = (dly != '0) ? DLY : OUT;
            end
            DLY: begin
                if (STOP)                          nxt = IDLE;
                else if (dly == DELAY_WIDTH'(1))   nxt = OUT;
            end
            OUT: begin
                if (TX_DST_RDY) begin
                    if (stop_pend || STOP)                   nxt = IDLE;
                    else if (SENT_CNT + 32'd1 == trans_count) nxt = FIN;
                    else                                      nxt = GEN;
                end
            end
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int f = 0; f < 5; f++) begin
                rc[f] <= 4'd1;
                for (int i = 0; i < NUM_RANGES; i++) begin
                    base[f][i] <= '0;
                    mask[f][i] <= '1;
                end
            end
            trans_count <= 32'(TRANS_CNT_DEF);
            seed        <= 32'd1;
            lfsr        <= 32'd1;
            g           <= 3'd0;
            dly         <= '0;
            stop_pend   <= 1'b0;
            SENT_CNT    <= 32'd0;
            TX_OP       <= 4'd0;
            TX_MOVI     <= 2'd0;
            TX_REG_A    <= '0;
            TX_REG_B    <= '0;
            TX_MEM      <= '0;
            TX_IMM      <= '0;
        end else begin
            if (CFG_WE && state == IDLE) begin
                if (!CFG_ADDR[7]) begin
                    if (CFG_ADDR[6:4] < 3'd5 && {1'b0, CFG_ADDR[3:1]} < NR) begin
                        if (CFG_ADDR[0]) mask[CFG_ADDR[6:4]][CFG_ADDR[IW:1]] <= CFG_WDATA[FW-1:0];
                        else             base[CFG_ADDR[6:4]][CFG_ADDR[IW:1]] <= CFG_WDATA[FW-1:0];
                    end
                end else if (CFG_ADDR == 8'h80) begin
                    trans_count <= CFG_WDATA;
                end else if (CFG_ADDR == 8'h81) begin
                    seed <= CFG_WDATA;
                end else if (CFG_ADDR >= 8'h82 && CFG_ADDR <= 8'h86) begin
                    // zero would make the modulo undefined, so it reads back as one range
                    if (CFG_WDATA == 32'd0)                   rc[CFG_ADDR[2:0] - 3'd2] <= 4'd1;
                    else if (CFG_WDATA > 32'(NUM_RANGES))     rc[CFG_ADDR[2:0] - 3'd2] <= NR;
                    else                                      rc[CFG_ADDR[2:0] - 3'd2] <= CFG_WDATA[3:0];
                end
            end

            if (state == IDLE && start_ok) begin
                SENT_CNT <= 32'd0;
                lfsr     <= (seed == 32'd0) ? 32'd1 : seed;
            end

            g         <= (state == GEN) ? g + 3'd1 : 3'd0;
            stop_pend <= (state == OUT) && (nxt == OUT) && (stop_pend || STOP);

            case (state)
                GEN: begin
                    lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'd0);
                    case (g)
                        3'd0: dly      <= draw[DELAY_WIDTH-1:0];
                        3'd1: TX_REG_A <= draw[DATA_WIDTH-1:0];
                        3'd2: TX_REG_B <= draw[DATA_WIDTH-1:0];
                        3'd3: TX_MEM   <= draw[DATA_WIDTH-1:0];
                        3'd4: TX_IMM   <= draw[DATA_WIDTH-1:0];
                        3'd5: begin
                            TX_OP   <= lfsr[3:0];
                            TX_MOVI <= lfsr[5:4];
                        end
                        default: ;
                    endcase
                end
                DLY: dly <= dly - DELAY_WIDTH'(1);
                OUT: if (TX_DST_RDY) SENT_CNT <= SENT_CNT + 32'd1;
                default: ;
            endcase
        end
    end
endmodule
